// File: rtl/button_input_16_if.sv
// CPU data-bus connection for the switch/button input controller.
interface button_input_16_if;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        we;

   modport master (output addr, output data_in, output we, input data_out);
   modport slave  (input addr, input data_in, input we, output data_out);
endinterface

// File: rtl/button_input_16.sv
// Synchronized, debounced Basys3 switches/buttons with sticky W1C press/release events and maskable irq.
// Optional macro BTN_AUTOREPEAT_EN: held buttons re-raise press events every REPEAT_COUNT clocks.
module button_input_16 #(
   parameter logic [15:0] BASE_ADDR    = 16'h1000,
   parameter int unsigned DB_COUNT     = 50000,
   parameter int unsigned REPEAT_COUNT = 25000000
) (
   input  logic               clk,
   input  logic               reset,
   button_input_16_if.slave   bus,
   input  logic [15:0]        sw,
   input  logic [4:0]         btn,
   output logic               irq
);

   localparam int unsigned     NIN    = 21;
   localparam int unsigned     DB_W   = $clog2(DB_COUNT);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_COUNT - 1);

   logic [NIN-1:0] w_raw;
   logic [NIN-1:0] r_s1;
   logic [NIN-1:0] r_s2;
   logic [NIN-1:0] w_deb;
   logic [4:0]     w_deb_btn;
   logic [4:0]     r_deb_d;
   logic [4:0]     w_rep_set;
   logic [4:0]     w_set_press;
   logic [4:0]     w_set_rel;
   logic [4:0]     w_clr_press;
   logic [4:0]     w_clr_rel;
   logic [4:0]     r_press;
   logic [4:0]     r_rel;
   logic [4:0]     r_mask;
   logic           r_irq;
   logic           w_sel;
   logic           w_wr;
   logic           w_unused;

   assign w_raw = {btn, sw};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end

   // Per-bit debounce: the synchronized value must disagree for DB_COUNT consecutive clocks.
   for (genvar g = 0; g < NIN; g++) begin : g_db
      logic [DB_W-1:0] r_cnt;
      logic            r_deb_bit;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_cnt     <= '0;
            r_deb_bit <= 1'b0;
         end else if (r_s2[g] == r_deb_bit) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_MAX) begin
            r_deb_bit <= r_s2[g];
            r_cnt     <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_deb[g] = r_deb_bit;
   end

   assign w_deb_btn = w_deb[20:16];

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned      REP_W   = $clog2(REPEAT_COUNT);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_COUNT - 1);

   for (genvar g = 0; g < 5; g++) begin : g_rep
      logic [REP_W-1:0] r_rep;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_rep <= '0;
         end else if (!w_deb_btn[g] || r_rep == REP_MAX) begin
            r_rep <= '0;
         end else begin
            r_rep <= r_rep + 1'b1;
         end
      end

      assign w_rep_set[g] = w_deb_btn[g] && (r_rep == REP_MAX);
   end
`else
   assign w_rep_set = '0;
`endif

   assign w_sel = (bus.addr[15:8] == BASE_ADDR[15:8]);
   assign w_wr  = bus.we && w_sel;

   assign w_set_press = (w_deb_btn & ~r_deb_d) | w_rep_set;
   assign w_set_rel   = ~w_deb_btn & r_deb_d;
   assign w_clr_press = (w_wr && bus.addr[7:0] == 8'h04) ? bus.data_in[4:0] : 5'b0;
   assign w_clr_rel   = (w_wr && bus.addr[7:0] == 8'h06) ? bus.data_in[4:0] : 5'b0;

   // Set is OR-ed in after the clear so a simultaneous set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_deb_d <= '0;
         r_press <= '0;
         r_rel   <= '0;
         r_mask  <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_deb_d <= w_deb_btn;
         r_press <= (r_press & ~w_clr_press) | w_set_press;
         r_rel   <= (r_rel & ~w_clr_rel) | w_set_rel;
         r_irq   <= |(r_press & r_mask);
         if (w_wr && bus.addr[7:0] == 8'h08) begin
            r_mask <= bus.data_in[4:0];
         end
      end
   end

   assign irq = r_irq;

   // NOTE: default assigned first so no path through the case leaves data_out latched.
   always_comb begin
      bus.data_out = '0;
      if (w_sel) begin
         case (bus.addr[7:0])
            8'h00:   bus.data_out = w_deb[15:0];
            8'h02:   bus.data_out = {11'b0, w_deb_btn};
            8'h04:   bus.data_out = {11'b0, r_press};
            8'h06:   bus.data_out = {11'b0, r_rel};
            8'h08:   bus.data_out = {11'b0, r_mask};
            default: bus.data_out = '0;
         endcase
      end
   end

   assign w_unused = &{1'b0, bus.data_in[15:5]};

endmodule

// File: tb/tb_button_input_16.sv
// Directed, table-driven bench for button_input_16 (DB_COUNT=4, REPEAT_COUNT=20, BASE_ADDR=16'h1000).
module tb_button_input_16;

   localparam int unsigned DB  = 4;
   localparam int unsigned REP = 20;
   localparam int unsigned SETTLE = DB + 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sw;
   logic [4:0]  btn;
   logic        irq;
   int          n_cmp = 0;
   int          n_bad = 0;

   button_input_16_if bus_if ();

   button_input_16 #(
      .BASE_ADDR    (16'h1000),
      .DB_COUNT     (DB),
      .REPEAT_COUNT (REP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .sw    (sw),
      .btn   (btn),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] sw;
      logic [4:0]  btn;
      logic [15:0] addr;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [11];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      bus_if.addr = a;
      #1 d = bus_if.data_out;
   endtask

   task automatic check_rd(input string name, input logic [15:0] a, input logic [15:0] exp);
      logic [15:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic check_irq(input string name, input logic exp);
      check(name, {15'b0, irq}, {15'b0, exp});
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus_if.addr    = a;
      bus_if.data_in = d;
      bus_if.we      = 1'b1;
      @(negedge clk);
      bus_if.we      = 1'b0;
   endtask

   task automatic clear_events();
      wr(16'h1004, 16'h001F);
      wr(16'h1006, 16'h001F);
   endtask

   initial begin
      logic [15:0] d;
      int          n_ev;
      int          exp_ev;

      vecs[0]  = '{"sw_a5a5",      16'hA5A5, 5'h00, 16'h1000, 16'hA5A5};
      vecs[1]  = '{"other_page",   16'hA5A5, 5'h00, 16'h2000, 16'h0000};
      vecs[2]  = '{"sw_5a0f",      16'h5A0F, 5'h00, 16'h1000, 16'h5A0F};
      vecs[3]  = '{"btn_15",       16'h5A0F, 5'h15, 16'h1002, 16'h0015};
      vecs[4]  = '{"press_15",     16'h5A0F, 5'h15, 16'h1004, 16'h0015};
      vecs[5]  = '{"no_release",   16'h5A0F, 5'h15, 16'h1006, 16'h0000};
      vecs[6]  = '{"release_15",   16'hFFFF, 5'h00, 16'h1006, 16'h0015};
      vecs[7]  = '{"press_sticky", 16'hFFFF, 5'h00, 16'h1004, 16'h0015};
      vecs[8]  = '{"odd_offset",   16'hFFFF, 5'h00, 16'h1001, 16'h0000};
      vecs[9]  = '{"sw_zero",      16'h0000, 5'h00, 16'h1000, 16'h0000};
      vecs[10] = '{"hole_0a",      16'h0000, 5'h00, 16'h100A, 16'h0000};

      reset          = 1'b1;
      sw             = '0;
      btn            = '0;
      bus_if.addr    = '0;
      bus_if.data_in = '0;
      bus_if.we      = 1'b0;
      tick(2);
      reset = 1'b0;

      // Build non-zero state, then reset asynchronously between edges.
      wr(16'h1008, 16'h001F);
      sw  = 16'hFFFF;
      btn = 5'h01;
      tick(SETTLE);
      check_irq("pre_reset_irq", 1'b1);
      reset = 1'b1;
      #1;
      check_rd("rst_sw",    16'h1000, 16'h0000);
      check_rd("rst_btn",   16'h1002, 16'h0000);
      check_rd("rst_press", 16'h1004, 16'h0000);
      check_rd("rst_mask",  16'h1008, 16'h0000);
      check_irq("rst_irq", 1'b0);
      sw = 16'h0000;
      tick(1);
      reset = 1'b0;
      tick(DB + 1);
      check_rd("deb_latency_early", 16'h1002, 16'h0000);
      tick(1);
      check_rd("deb_latency_hit", 16'h1002, 16'h0001);
      tick(2);
      check_rd("post_rst_press", 16'h1004, 16'h0001);
      check_irq("post_rst_irq_masked", 1'b0);
      btn = 5'h00;
      tick(SETTLE);
      clear_events();

      for (int i = 0; i < 11; i++) begin
         sw  = vecs[i].sw;
         btn = vecs[i].btn;
         tick(SETTLE);
         check_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end
      clear_events();

      // Glitch rejection on sw[3].
      sw = 16'h0008;
      tick(3);
      sw = 16'h0000;
      tick(10);
      check_rd("sw_glitch", 16'h1000, 16'h0000);
      sw = 16'h0008;
      tick(10);
      check_rd("sw_hold", 16'h1000, 16'h0008);
      sw = 16'h0000;
      tick(SETTLE);
      check_rd("sw_no_event", 16'h1004, 16'h0000);

      // btn[2] press, release, W1C.
      btn = 5'h04;
      tick(SETTLE);
      check_rd("btn2_press", 16'h1004, 16'h0004);
      check_rd("btn2_no_rel", 16'h1006, 16'h0000);
      btn = 5'h00;
      tick(SETTLE);
      check_rd("btn2_rel", 16'h1006, 16'h0004);
      wr(16'h1006, 16'h0004);
      check_rd("btn2_rel_clr", 16'h1006, 16'h0000);
      check_rd("btn2_press_kept", 16'h1004, 16'h0004);
      clear_events();

      // Mask register and irq timing.
      wr(16'h1008, 16'hFFE2);
      check_rd("mask_wr", 16'h1008, 16'h0002);
      wr(16'h2008, 16'h001F);
      check_rd("mask_other_page", 16'h1008, 16'h0002);
      btn = 5'h02;
      tick(DB + 2);
      check_rd("btn1_press_pending", 16'h1004, 16'h0000);
      check_irq("irq_before_evt", 1'b0);
      tick(1);
      check_rd("btn1_press_set", 16'h1004, 16'h0002);
      check_irq("irq_same_as_evt", 1'b0);
      tick(1);
      check_irq("irq_rise", 1'b1);
      wr(16'h1004, 16'h0002);
      check_rd("btn1_press_clr", 16'h1004, 16'h0000);
      check_irq("irq_hold_after_clr", 1'b1);
      tick(1);
      check_irq("irq_fall", 1'b0);
      btn = 5'h00;
      tick(SETTLE);
      clear_events();
      btn = 5'h08;
      tick(SETTLE);
      check_irq("irq_masked_btn3", 1'b0);
      check_rd("btn3_press", 16'h1004, 16'h0008);
      btn = 5'h00;
      tick(SETTLE);
      clear_events();

      // Clear on the same edge that sets press_evt[4].
      btn = 5'h10;
      tick(DB + 2);
      wr(16'h1004, 16'h0010);
      check_rd("set_wins", 16'h1004, 16'h0010);
      wr(16'h1004, 16'h0010);
      check_rd("later_clear", 16'h1004, 16'h0000);
      btn = 5'h00;
      tick(SETTLE);
      clear_events();

      // Held btn[0]: count press events, clearing each one.
      btn = 5'h01;
      tick(DB + 2);
      n_ev = 0;
      for (int c = 0; c < 70; c++) begin
         tick(1);
         bus_if.we = 1'b0;
         rd(16'h1004, d);
         if (d[0]) begin
            n_ev++;
            bus_if.data_in = 16'h0001;
            bus_if.we      = 1'b1;
         end
      end
      tick(1);
      bus_if.we = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      exp_ev = 4;
`else
      exp_ev = 1;
`endif
      check("hold_event_count", 16'(n_ev), 16'(exp_ev));
      btn = 5'h00;
      tick(SETTLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/button_input_16.md
Name: button_input_16

Overview:
- Memory-mapped input controller for the Basys3 on-board switches and buttons, on the CPU's 16-bit data bus.
- Complements the existing basic I/O block: it supplies clean, synchronized, debounced switch and button values.
- Adds sticky press/release event registers with write-1-to-clear, plus a maskable interrupt request.
- Sits at its own BASE_ADDR page, alongside the basic I/O block.

Parameters:
- BASE_ADDR, 1000: register page base; only BASE_ADDR[15:8] is decoded.
- DB_COUNT, 50000: number of consecutive clocks a synchronized input must differ from its debounced value before the debounced value updates; must be >= 2.
- REPEAT_COUNT, 25000000: auto-repeat interval in clocks; used only when BTN_AUTOREPEAT_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- addr  input  16  register address
- data_in  input  16  write data
- data_out  output  16  read data, combinational from addr
- we  input  1  write enable, sampled on posedge clk
- sw  input  16  raw switches, asynchronous to clk
- btn  input  5  raw buttons: bit0 btnC, bit1 btnU, bit2 btnL, bit3 btnR, bit4 btnD
- irq  output  1  registered interrupt request, active-high

Behaviour:
- Reset is asynchronous and active-high. While asserted, all of the following are 0: sync flops, debounce counters, debounced values, press/release events, irq_mask, irq. data_out then reads as the zeroed register contents.
- Synchronizer: each of the 21 inputs passes through a 2-flop synchronizer (s1 -> s2).
- Debounce, per bit, with a counter of width $clog2(DB_COUNT):
  - If s2 == debounced: counter <= 0.
  - Else, if counter == DB_COUNT-1: debounced <= s2 and counter <= 0.
  - Else: counter <= counter + 1.
  - A glitch shorter than DB_COUNT clocks never reaches the debounced value.
  - Latency: a clean input change registered into s1 at edge 0 appears on debounced at edge DB_COUNT+1.
- Edge detect, per button: deb_d <= debounced.
  - press_evt[i] sets when debounced[i] & ~deb_d[i].
  - release_evt[i] sets when ~debounced[i] & deb_d[i].
  - Events are set on the edge after the debounced value changes.
- Events are sticky until cleared.
  - A write to the event register clears the bits where data_in is 1; bits where data_in is 0 are untouched.
  - If set and clear hit the same bit in the same cycle, set wins.
- irq <= |(press_evt & irq_mask), registered: it follows the event by one clock and drops one clock after the clear.
- Register map. Decode requires addr[15:8] == BASE_ADDR[15:8]; reads of any other address return 0, and writes elsewhere are ignored.
  - +0x00 R: {debounced sw[15:0]}
  - +0x02 R: {11'b0, debounced btn[4:0]}
  - +0x04 R/W1C: {11'b0, press_evt[4:0]}
  - +0x06 R/W1C: {11'b0, release_evt[4:0]}
  - +0x08 R/W: {11'b0, irq_mask[4:0]}; data_in[15:5] ignored
- Reads have no side effects.
- Switch changes generate no events.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined:
  - Each button has a repeat counter that is 0 while the debounced button is 0, and increments every clock while it is 1.
  - When the counter reaches REPEAT_COUNT-1 it wraps to 0 and press_evt[i] sets again; the set-wins rule still applies.
  - A held button therefore generates one event at press, then one every REPEAT_COUNT clocks.
- Undefined: no repeat counters exist and REPEAT_COUNT is unused; exactly one press event per debounced rising edge.

Test Plan (DB_COUNT=4, REPEAT_COUNT=20, BASE_ADDR=16'h1000):
- Assert reset mid-count with btn[0]=1 held -> all reads return 0 and irq=0 immediately; after release, the debounced btn[0] reaches 1 DB_COUNT+1 edges after btn[0] is registered into s1.
- Pulse sw[3]=1 for 3 clocks, then 0 -> read 0x1000 stays 16'h0000; hold sw[3]=1 for 10 clocks -> read 0x1000 = 16'h0008.
- Press and hold btn[2] -> 0x1004 reads 16'h0004 and 0x1006 reads 0. Release -> 0x1006 reads 16'h0004. Write 16'h0004 to 0x1006 -> reads 0; 0x1004 still reads 16'h0004.
- Write 16'h0002 to 0x1008, then press btn[1] -> irq rises one clock after press_evt[1]. Write 16'h0002 to 0x1004 -> irq falls one clock later. Press btn[3] with mask=0x0002 -> irq stays 0.
- Issue a W1C of press_evt[4] on the same clock that the btn[4] rising edge sets it -> bit remains 1 (set wins).
- With BTN_AUTOREPEAT_EN defined, hold btn[0] for 70 clocks after debounce, clearing each event as it appears -> exactly 4 press events (1 initial + 3 repeats); without the macro -> exactly 1.
